// File: rtl/panel_jam_seq_pkg.sv
// panel_pkg: shared front-panel modes, sequencer states and default 8080 opcodes
package panel_pkg;
    typedef enum logic {PM_EXAMINE, PM_EXAMINE_NEXT} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;
    localparam logic [7:0] OP_JMP = 8'hC3;
    localparam logic [7:0] OP_NOP = 8'h00;
endpackage

// File: rtl/panel_jam_seq_rd_edge_detect.sv
// rd_edge_detect: registered previous rd with rise/fall strobes
module rd_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic rd,
    output logic rise,
    output logic fall
);
    logic prev_rd;
    always_ff @(posedge clk) prev_rd <= reset ? 1'b0 : rd;
    assign rise = rd & ~prev_rd;
    assign fall = ~rd & prev_rd;
endmodule

// File: rtl/panel_jam_seq.sv
// panel_jam_seq: jams JMP+address or a NOP run onto the CPU data-in bus, one byte per read
module panel_jam_seq
    import panel_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] JMP_OP = DATA_W'(OP_JMP),
    parameter logic [DATA_W-1:0] NOP_OP = DATA_W'(OP_NOP),
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              abort,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              jam_active,
    output logic              done
);
    typedef logic [CNT_W:0] idx_t;
    localparam idx_t EX_LEN = idx_t'(ADDR_W / DATA_W + 1);
    state_t            state;
    mode_t             mode_r;
    logic [ADDR_W-1:0] addr_sr;
    idx_t              len;
    idx_t              idx;
    logic              rise;
    logic              fall;
    rd_edge_detect u_edge (
        .clk  (clk),
        .reset(reset),
        .rd   (rd),
        .rise (rise),
        .fall (fall)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            jam_active <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            mode_r     <= PM_EXAMINE;
            addr_sr    <= '0;
            len        <= '0;
            idx        <= '0;
        end else if (abort && state != S_IDLE) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            jam_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    mode_r     <= mode_t'(cmd_mode);
                    addr_sr    <= cmd_addr;
                    idx        <= '0;
                    len        <= !cmd_mode ? EX_LEN : (cmd_count == '0) ? idx_t'(1) : idx_t'(cmd_count);
                    data_out   <= cmd_mode ? NOP_OP : JMP_OP;
                    state      <= S_FEED;
                    cmd_ready  <= 1'b0;
                    jam_active <= 1'b1;
                end
                S_FEED: if (rise) begin
                    idx <= idx + 1'b1;
                    if (idx + 1'b1 == len) begin
                        state <= S_DRAIN;
                    end else begin
                        data_out <= (mode_r == PM_EXAMINE) ? addr_sr[DATA_W-1:0] : NOP_OP;
                        addr_sr  <= addr_sr >> DATA_W;
                    end
                end
                S_DRAIN: if (fall || !rd) begin
                    state      <= S_DONE;
                    jam_active <= 1'b0;
                    done       <= 1'b1;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_panel_jam_seq.sv
// tb_panel_jam_seq: directed scoreboard bench for the front-panel jam sequencer
module tb_panel_jam_seq;
    logic        clk = 0;
    logic        reset = 1;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic        cmd_mode = 0;
    logic [15:0] cmd_addr = 0;
    logic [7:0]  cmd_count = 0;
    logic        abort = 0;
    logic        rd = 0;
    logic [7:0]  data_out;
    logic        jam_active;
    logic        done;
    int          total = 0;
    int          passed = 0;
    logic [7:0]  sb[$];

    panel_jam_seq dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_addr  (cmd_addr),
        .cmd_count (cmd_count),
        .abort     (abort),
        .rd        (rd),
        .data_out  (data_out),
        .jam_active(jam_active),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send(input string tag, input logic mode, input logic [15:0] addr, input logic [7:0] cnt);
        cmd_valid = 1;
        cmd_mode  = mode;
        cmd_addr  = addr;
        cmd_count = cnt;
        chk({tag, "_ready_idle"}, 16'(cmd_ready), 16'd1);
        tick();
        cmd_valid = 0;
        chk({tag, "_jam_on"}, 16'(jam_active), 16'd1);
        chk({tag, "_ready_busy"}, 16'(cmd_ready), 16'd0);
        if (!mode) begin
            sb.push_back(8'hC3);
            sb.push_back(addr[7:0]);
            sb.push_back(addr[15:8]);
        end else begin
            repeat ((cnt == 0) ? 1 : int'(cnt)) sb.push_back(8'h00);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s_sb observed=empty expected=byte", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_byte"}, 16'(data_out), 16'(e));
        end
    endtask

    task automatic cpu_read(input string tag);
        rd = 1;
        chk({tag, "_jam"}, 16'(jam_active), 16'd1);
        pop_chk(tag);
        tick();
        rd = 0;
        tick();
    endtask

    task automatic finish_seq(input string tag);
        chk({tag, "_done"}, 16'(done), 16'd1);
        chk({tag, "_jam_off"}, 16'(jam_active), 16'd0);
        tick();
        chk({tag, "_done_end"}, 16'(done), 16'd0);
        chk({tag, "_ready_back"}, 16'(cmd_ready), 16'd1);
        chk({tag, "_sb_drained"}, 16'(sb.size()), 16'd0);
    endtask

    initial begin
        tick();
        tick();
        reset = 0;
        chk("rst_ready", 16'(cmd_ready), 16'd1);
        chk("rst_jam", 16'(jam_active), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_data", 16'(data_out), 16'd0);

        send("ex", 1'b0, 16'h1234, 8'd0);
        cpu_read("ex_r0");
        cpu_read("ex_r1");
        cpu_read("ex_r2");
        finish_seq("ex");
        tick();

        send("exn3", 1'b1, 16'h0000, 8'd3);
        cpu_read("exn3_r0");
        cpu_read("exn3_r1");
        cpu_read("exn3_r2");
        finish_seq("exn3");
        rd = 1;
        chk("exn3_r3_unjammed", 16'(jam_active), 16'd0);
        tick();
        rd = 0;
        chk("exn3_r3_no_done", 16'(done), 16'd0);
        tick();

        send("exn0", 1'b1, 16'h0000, 8'd0);
        cpu_read("exn0_r0");
        finish_seq("exn0");
        tick();

        rd = 1;
        tick();
        send("hold", 1'b0, 16'hABCD, 8'd0);
        tick();
        chk("hold_no_consume0", 16'(data_out), 16'h00C3);
        tick();
        chk("hold_no_consume1", 16'(data_out), 16'h00C3);
        rd = 0;
        tick();
        cpu_read("hold_r0");
        cpu_read("hold_r1");
        rd = 1;
        pop_chk("hold_r2");
        repeat (3) begin
            tick();
            chk("hold_drain_jam", 16'(jam_active), 16'd1);
            chk("hold_drain_done", 16'(done), 16'd0);
        end
        rd = 0;
        tick();
        finish_seq("hold");
        tick();

        send("ab", 1'b0, 16'h5678, 8'd0);
        cpu_read("ab_r0");
        rd = 1;
        abort = 1;
        pop_chk("ab_r1");
        tick();
        abort = 0;
        rd = 0;
        chk("ab_jam_off", 16'(jam_active), 16'd0);
        chk("ab_ready", 16'(cmd_ready), 16'd1);
        chk("ab_done0", 16'(done), 16'd0);
        sb.delete();
        repeat (3) begin
            tick();
            chk("ab_no_done", 16'(done), 16'd0);
        end

        send("rs", 1'b0, 16'h1111, 8'd0);
        cpu_read("rs_r0");
        reset = 1;
        tick();
        reset = 0;
        chk("rs_ready", 16'(cmd_ready), 16'd1);
        chk("rs_jam", 16'(jam_active), 16'd0);
        chk("rs_done", 16'(done), 16'd0);
        chk("rs_data", 16'(data_out), 16'd0);
        sb.delete();
        tick();

        send("ign", 1'b0, 16'hBEEF, 8'd0);
        cpu_read("ign_r0");
        cmd_valid = 1;
        cmd_mode  = 1;
        cmd_count = 8'd5;
        cmd_addr  = 16'h0000;
        tick();
        tick();
        cmd_valid = 0;
        chk("ign_ready", 16'(cmd_ready), 16'd0);
        cpu_read("ign_r1");
        cpu_read("ign_r2");
        finish_seq("ign");
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
